// File: rtl/serial_subtractor_if.sv
// ---------------------------------------------------------------------------
// serial_subtractor_if
//   Bundles the start/done handshake and the operand/result bus of the
//   digit-serial subtractor so requester and datapath share one port.
//
//   Signals (N = operand width):
//     start     requester -> subtractor  request, honoured only while busy==0
//     in1       requester -> subtractor  minuend, captured with accepted start
//     in2       requester -> subtractor  subtrahend, captured with accepted start
//     busy      subtractor -> requester  high while a subtraction is running
//     done      subtractor -> requester  one-cycle pulse, result fields valid
//     diff      subtractor -> requester  in1 - in2 mod 2^N
//     bout      subtractor -> requester  borrow (in1 < in2 unsigned)
//     overflow  subtractor -> requester  signed overflow of the subtraction
//
//   Modports: master = requester side, slave = subtractor side.
// ---------------------------------------------------------------------------
interface serial_subtractor_if #(
  parameter int N = 32
);
  logic         start;
  logic [N-1:0] in1;
  logic [N-1:0] in2;
  logic         busy;
  logic         done;
  logic [N-1:0] diff;
  logic         bout;
  logic         overflow;

  modport master (
    output start, in1, in2,
    input  busy, done, diff, bout, overflow
  );

  modport slave (
    input  start, in1, in2,
    output busy, done, diff, bout, overflow
  );
endinterface

// File: rtl/serial_subtractor.sv
// ---------------------------------------------------------------------------
// serial_subtractor
//   Digit-serial two's-complement subtractor. Computes in1 - in2 as
//   in1 + ~in2 + 1, D bits per clock, least-significant digit first, so one
//   operation takes N/D clocks in RUN plus one DONE cycle.
//
//   Parameters:
//     N  operand/result width (N % D must be 0)
//     D  digit width handled per clock (1 <= D <= N)
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    serial_subtractor_if slave modport (start/in1/in2 in,
//            busy/done/diff/bout/overflow out, all outputs registered)
// ---------------------------------------------------------------------------
module serial_subtractor #(
  parameter int N = 32,
  parameter int D = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_subtractor_if.slave bus
);

  localparam int NDIG = N / D;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  // Reject widths that do not split into whole digits at elaboration time.
  generate
    if ((D < 1) || (D > N) || ((N % D) != 0)) begin : gen_param_check
      $error("serial_subtractor: N must be a multiple of D and 1 <= D <= N");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  a_q;
  logic [N-1:0]  b_q;
  logic [N-1:0]  res_q;
  logic [N-1:0]  diff_q;
  logic          carry_q;
  logic          busy_q;
  logic          done_q;
  logic          bout_q;
  logic          ovf_q;
  logic [CW-1:0] cnt_q;

  logic [D-1:0]  digitSum;
  logic [D:0]    carryChain;
  logic [N-1:0]  res_d;
  logic          lastDigit;

  // Ripple full-adder chain for the current digit. The operand registers
  // shift right each RUN cycle, so the active digit always sits in the low
  // D bits. carryChain[D-1] is the carry into the digit's MSB, which on the
  // final digit is the carry into bit N-1 needed for signed overflow.
  always_comb begin
    carryChain    = '0;
    digitSum      = '0;
    carryChain[0] = carry_q;
    for (int i = 0; i < D; i++) begin
      digitSum[i]     = a_q[i] ^ b_q[i] ^ carryChain[i];
      carryChain[i+1] = (a_q[i] & b_q[i]) | (carryChain[i] & (a_q[i] ^ b_q[i]));
    end
  end

  // New digits enter the result register at the top, so after N/D shifts
  // the least-significant digit has arrived at bit 0.
  always_comb begin
    res_d     = (res_q >> D) | (N'(digitSum) << (N - D));
    lastDigit = (cnt_q == CW'(NDIG - 1));
  end

  // Control FSM and datapath registers. Loading subtracts by storing ~in2
  // with an initial carry of 1. Result outputs only update on the
  // completing edge and otherwise hold the previous result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            a_q     <= bus.in1;
            b_q     <= ~bus.in2;
            res_q   <= '0;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end

        RUN: begin
          a_q     <= a_q >> D;
          b_q     <= b_q >> D;
          res_q   <= res_d;
          carry_q <= carryChain[D];
          cnt_q   <= cnt_q + 1'b1;
          if (lastDigit) begin
            diff_q  <= res_d;
            bout_q  <= ~carryChain[D];
            ovf_q   <= carryChain[D-1] ^ carryChain[D];
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end

        DONE: begin
          done_q <= 1'b0;
          // busy is low here, so a request is accepted back-to-back.
          if (bus.start) begin
            a_q     <= bus.in1;
            b_q     <= ~bus.in2;
            res_q   <= '0;
            carry_q <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end else begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.diff     = diff_q;
  assign bus.bout     = bout_q;
  assign bus.overflow = ovf_q;

endmodule
